instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC loaded on reset.
REQ-002 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 RST_N  input  1  SHALL be the reset: asynchronous assertion, active-low.
REQ-004 redirect  input  1  SHALL request a PC change (branch/jump taken) this cycle.
REQ-005 redirect_pc  input  32  SHALL be the new fetch address; bits [1:0] are forced to 0 internally.
REQ-006 imem_req  output  1  SHALL request an instruction memory read.
REQ-007 imem_addr  output  32  SHALL be the word address of the request.
REQ-008 imem_gnt  input  1  SHALL accept the request in the cycle it and imem_req are both high.
REQ-009 imem_rvalid  input  1  SHALL mark imem_rdata valid; arrives one or more cycles after grant.
REQ-010 imem_rdata  input  32  SHALL carry the fetched instruction word.
REQ-011 ir  output  32  SHALL be the registered instruction presented to decode and immediate generation.
REQ-012 ir_pc  output  32  SHALL be the address from which ir was fetched.
REQ-013 ir_valid  output  1  SHALL mark ir/ir_pc valid.
REQ-014 ir_ready  input  1  SHALL indicate decode consumes ir this cycle.

Function
REQ-015 FSM states SHALL be FETCH, WAIT, FULL; at most one memory request outstanding.
REQ-016 FETCH: imem_req=1, imem_addr=pc; on imem_gnt, inflight_pc<=pc, pc<=pc+4, go WAIT.
REQ-017 imem_addr and imem_req SHALL stay stable in FETCH until granted.
REQ-018 WAIT: imem_req=0; on imem_rvalid with squash=0, ir<=imem_rdata, ir_pc<=inflight_pc, ir_valid<=1, go FULL.
REQ-019 FULL: ir_valid=1, ir/ir_pc held; on ir_valid and ir_ready, ir_valid<=0, go FETCH next cycle.
REQ-020 PC increment SHALL be modulo 2^32 (32'hFFFF_FFFC + 4 = 32'h0000_0000).
REQ-021 redirect SHALL have priority over all other events: pc<=redirect_pc, ir_valid<=0 next cycle.
REQ-022 redirect in FULL SHALL discard ir and go FETCH; in FETCH without grant, stay FETCH at new pc.
REQ-023 redirect in FETCH coinciding with imem_gnt SHALL go WAIT with squash<=1; pc SHALL NOT also increment.
REQ-024 redirect in WAIT without imem_rvalid SHALL set squash<=1 and stay WAIT.
REQ-025 redirect in WAIT coinciding with imem_rvalid SHALL drop the data and go FETCH.
REQ-026 WAIT with squash=1 on imem_rvalid SHALL drop the data, clear squash, go FETCH; ir unchanged, ir_valid stays 0.
REQ-027 imem_rvalid SHALL be ignored outside WAIT.
REQ-028 Minimum latency: grant cycle N, rvalid cycle N+1, ir_valid=1 in cycle N+2.

Reset
REQ-029 RST_N low SHALL immediately set state=FETCH, pc=RESET_PC, inflight_pc=0, squash=0, ir=0, ir_pc=0, ir_valid=0.
REQ-030 During reset imem_req SHALL be 1 with imem_addr=RESET_PC, but no grant is acted on until RST_N is high.
REQ-031 Reset mid-request SHALL abandon the outstanding read; its late rvalid SHALL be ignored per REQ-027.

Structure
REQ-032 Shared package otter_pkg SHALL hold fetch state encodings, INSTR_BYTES=4, and the default RESET_PC.
REQ-033 One sub-module fetch_pc_reg SHALL hold pc with load (redirect), increment (grant) and async reset.
REQ-034 FSM, squash flag and ir/ir_pc/ir_valid registers SHALL reside in instr_fetch.

Verification
REQ-035 Reset release, gnt=1 always, rvalid 1 cycle after gnt, ir_ready=1 -> imem_addr sequence 0x0,0x4,0x8; ir_pc matches; ir = rdata.
REQ-036 ir_ready=0 for 5 cycles with ir_valid=1 -> ir/ir_pc constant, imem_req=0; release -> next address fetched.
REQ-037 redirect to 0x0000_0103 while WAIT, rvalid 3 cycles later -> data dropped, ir_valid=0, next imem_addr=0x0000_0100.
REQ-038 redirect and imem_gnt same cycle at pc=0x10 -> response dropped, next request at redirect_pc, never 0x14.
REQ-039 RESET_PC=0xFFFF_FFFC, sequential fetch -> addresses 0xFFFF_FFFC then 0x0000_0000.
REQ-040 RST_N low in WAIT, rvalid during FETCH after release -> ignored, first ir equals data from RESET_PC fetch.

Source files
------------

// File: rtl/otter_pkg.sv
// rtl/otter_pkg.sv - shared fetch-stage types, constants and helpers
package otter_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      FULL  = 2'd2
   } fetch_state_e;

   localparam logic [31:0] INSTR_BYTES      = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'd3;
   endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - program counter with redirect load and post-grant increment
module fetch_pc_reg
   import otter_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [31:0] load_pc,
   input  logic        inc,
   output logic [31:0] pc
);

   logic [31:0] pc_d;
   logic [31:0] pc_q;

   // A redirect wins over an increment so a same-cycle grant never skips ahead.
   always_comb begin
      pc_d = pc_q;
      if (load) begin
         pc_d = word_align(load_pc);
      end else if (inc) begin
         pc_d = pc_q + INSTR_BYTES;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - single-outstanding instruction fetch with redirect squash
module instr_fetch
   import otter_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] ir,
   output logic [31:0] ir_pc,
   output logic        ir_valid,
   input  logic        ir_ready
);

   fetch_state_e state_d, state_q;
   logic         squash_d, squash_q;
   logic [31:0]  inflight_pc_d, inflight_pc_q;
   logic [31:0]  ir_d, ir_q;
   logic [31:0]  ir_pc_d, ir_pc_q;
   logic         ir_valid_d, ir_valid_q;
   logic         pc_inc;
   logic [31:0]  pc;

   fetch_pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (redirect),
      .load_pc (redirect_pc),
      .inc     (pc_inc),
      .pc      (pc)
   );

   always_comb begin
      state_d       = state_q;
      squash_d      = squash_q;
      inflight_pc_d = inflight_pc_q;
      ir_d          = ir_q;
      ir_pc_d       = ir_pc_q;
      ir_valid_d    = ir_valid_q;
      pc_inc        = 1'b0;

      case (state_q)
         FETCH: begin
            if (imem_gnt) begin
               state_d       = WAIT;
               inflight_pc_d = pc;
               squash_d      = redirect;
               pc_inc        = !redirect;
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               state_d  = FETCH;
               squash_d = 1'b0;
               if (!redirect && !squash_q) begin
                  ir_d       = imem_rdata;
                  ir_pc_d    = inflight_pc_q;
                  ir_valid_d = 1'b1;
                  state_d    = FULL;
               end
            end else if (redirect) begin
               // The read already in flight belongs to the old path.
               squash_d = 1'b1;
            end
         end
         FULL: begin
            if (redirect || ir_ready) begin
               ir_valid_d = 1'b0;
               state_d    = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase

      if (redirect) begin
         ir_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= FETCH;
         squash_q      <= 1'b0;
         inflight_pc_q <= 32'd0;
         ir_q          <= 32'd0;
         ir_pc_q       <= 32'd0;
         ir_valid_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         squash_q      <= squash_d;
         inflight_pc_q <= inflight_pc_d;
         ir_q          <= ir_d;
         ir_pc_q       <= ir_pc_d;
         ir_valid_q    <= ir_valid_d;
      end
   end

   assign imem_req  = (state_q == FETCH);
   assign imem_addr = pc;
   assign ir        = ir_q;
   assign ir_pc     = ir_pc_q;
   assign ir_valid  = ir_valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed scoreboard bench for instr_fetch
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        redirect, imem_gnt, imem_rvalid, ir_ready;
   logic [31:0] redirect_pc, imem_rdata;
   logic        imem_req, ir_valid;
   logic [31:0] imem_addr, ir, ir_pc;

   logic        gnt2, rvalid2;
   logic [31:0] rdata2;
   logic        imem_req2, ir_valid2;
   logic [31:0] imem_addr2, ir2, ir_pc2;

   int checks = 0;
   int errors = 0;
   logic [63:0] sb_q[$];
   logic [63:0] sb_exp;

   always #5 clk = ~clk;

   instr_fetch dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .ir          (ir),
      .ir_pc       (ir_pc),
      .ir_valid    (ir_valid),
      .ir_ready    (ir_ready)
   );

   instr_fetch #(
      .RESET_PC (32'hFFFF_FFFC)
   ) dut2 (
      .clk         (clk),
      .rst_n       (rst_n),
      .redirect    (1'b0),
      .redirect_pc (32'd0),
      .imem_req    (imem_req2),
      .imem_addr   (imem_addr2),
      .imem_gnt    (gnt2),
      .imem_rvalid (rvalid2),
      .imem_rdata  (rdata2),
      .ir          (ir2),
      .ir_pc       (ir_pc2),
      .ir_valid    (ir_valid2),
      .ir_ready    (1'b1)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sb_pop_check();
      checks++;
      assert (sb_q.size() > 0)
      else begin
         errors++;
         $error("FAIL sb_underflow observed=%0d expected=nonzero", sb_q.size());
      end
      if (sb_q.size() > 0) begin
         sb_exp = sb_q.pop_front();
         chk("ir_data", ir, sb_exp[31:0]);
         chk("ir_pc", ir_pc, sb_exp[63:32]);
      end
   endtask

   // Grant at a, return data one cycle later; ends in the FULL cycle.
   task automatic do_fetch(input logic [31:0] a);
      chk("req_in_fetch", {31'd0, imem_req}, 32'd1);
      chk("addr_in_fetch", imem_addr, a);
      imem_gnt = 1'b1;
      sb_q.push_back({a, mem_word(a)});
      cycle();
      imem_gnt = 1'b0;
      chk("req_in_wait", {31'd0, imem_req}, 32'd0);
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(a);
      cycle();
      imem_rvalid = 1'b0;
      imem_rdata  = 32'd0;
      chk("ir_valid_full", {31'd0, ir_valid}, 32'd1);
      sb_pop_check();
   endtask

   initial begin
      rst_n = 1'b1;
      redirect = 1'b0; redirect_pc = 32'd0;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0; ir_ready = 1'b1;
      gnt2 = 1'b0; rvalid2 = 1'b0; rdata2 = 32'd0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_req", {31'd0, imem_req}, 32'd1);
      chk("rst_addr", imem_addr, 32'd0);
      chk("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
      chk("rst_ir", ir, 32'd0);
      chk("rst_ir_pc", ir_pc, 32'd0);
      chk("rst_addr2", imem_addr2, 32'hFFFF_FFFC);
      imem_gnt = 1'b1;
      cycle();
      cycle();
      chk("rst_gnt_ignored", imem_addr, 32'd0);
      imem_gnt = 1'b0;
      rst_n = 1'b1;
      cycle();
      chk("post_rst_addr", imem_addr, 32'd0);
      chk("post_rst_req", {31'd0, imem_req}, 32'd1);

      // sequential fetch with decode always ready
      do_fetch(32'h0); cycle();
      do_fetch(32'h4); cycle();
      do_fetch(32'h8); cycle();

      // decode stall holds ir
      ir_ready = 1'b0;
      do_fetch(32'hC);
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("stall_valid", {31'd0, ir_valid}, 32'd1);
         chk("stall_ir", ir, mem_word(32'hC));
         chk("stall_ir_pc", ir_pc, 32'hC);
         chk("stall_req", {31'd0, imem_req}, 32'd0);
      end
      ir_ready = 1'b1;
      cycle();
      chk("stall_release_addr", imem_addr, 32'h10);
      chk("stall_release_req", {31'd0, imem_req}, 32'd1);

      // redirect coinciding with grant at 0x10
      redirect = 1'b1; redirect_pc = 32'h40; imem_gnt = 1'b1;
      cycle();
      redirect = 1'b0; imem_gnt = 1'b0;
      chk("rg_wait", {31'd0, imem_req}, 32'd0);
      imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0014;
      cycle();
      imem_rvalid = 1'b0;
      chk("rg_dropped", {31'd0, ir_valid}, 32'd0);
      chk("rg_next_addr", imem_addr, 32'h40);

      // redirect while waiting, data 3 cycles after grant
      imem_gnt = 1'b1;
      cycle();
      imem_gnt = 1'b0;
      redirect = 1'b1; redirect_pc = 32'h0000_0103;
      cycle();
      redirect = 1'b0;
      chk("rw_stay_wait", {31'd0, imem_req}, 32'd0);
      cycle();
      chk("rw_still_wait", {31'd0, imem_req}, 32'd0);
      imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0040;
      cycle();
      imem_rvalid = 1'b0;
      chk("rw_dropped", {31'd0, ir_valid}, 32'd0);
      chk("rw_ir_kept", ir_pc, 32'hC);
      chk("rw_next_addr", imem_addr, 32'h100);

      // redirect in FULL discards ir
      ir_ready = 1'b0;
      do_fetch(32'h100);
      redirect = 1'b1; redirect_pc = 32'h200;
      cycle();
      redirect = 1'b0; ir_ready = 1'b1;
      chk("rf_valid", {31'd0, ir_valid}, 32'd0);
      chk("rf_addr", imem_addr, 32'h200);

      // redirect in FETCH without grant
      redirect = 1'b1; redirect_pc = 32'h300;
      cycle();
      redirect = 1'b0;
      chk("rn_addr", imem_addr, 32'h300);
      chk("rn_req", {31'd0, imem_req}, 32'd1);

      // redirect coinciding with rvalid in WAIT
      imem_gnt = 1'b1;
      cycle();
      imem_gnt = 1'b0;
      redirect = 1'b1; redirect_pc = 32'h400; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0300;
      cycle();
      redirect = 1'b0; imem_rvalid = 1'b0;
      chk("rv_valid", {31'd0, ir_valid}, 32'd0);
      chk("rv_addr", imem_addr, 32'h400);

      // reset mid-request, late rvalid ignored
      imem_gnt = 1'b1;
      cycle();
      imem_gnt = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mr_req", {31'd0, imem_req}, 32'd1);
      chk("mr_addr", imem_addr, 32'd0);
      chk("mr_ir", ir, 32'd0);
      cycle();
      rst_n = 1'b1;
      imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      cycle();
      imem_rvalid = 1'b0;
      chk("mr_late_ignored", {31'd0, ir_valid}, 32'd0);
      chk("mr_addr_after", imem_addr, 32'd0);
      do_fetch(32'h0);
      cycle();

      // wrap-around from RESET_PC=0xFFFF_FFFC
      chk("wrap_addr0", imem_addr2, 32'hFFFF_FFFC);
      gnt2 = 1'b1;
      cycle();
      gnt2 = 1'b0;
      rvalid2 = 1'b1; rdata2 = mem_word(32'hFFFF_FFFC);
      cycle();
      rvalid2 = 1'b0;
      chk("wrap_valid", {31'd0, ir_valid2}, 32'd1);
      chk("wrap_ir_pc", ir_pc2, 32'hFFFF_FFFC);
      chk("wrap_ir", ir2, mem_word(32'hFFFF_FFFC));
      cycle();
      chk("wrap_addr1", imem_addr2, 32'h0);
      chk("wrap_req", {31'd0, imem_req2}, 32'd1);

      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
